// File: rtl/power_frame_scheduler.sv
// Aligns per-block powers from four Goertzel bins into one frame for the tone detector.
// A collect bank fills from the done strobes; an output bank holds the frame presented via valid/ready.
module power_frame_scheduler #(
   parameter int POWER_WIDTH    = 64,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TIMER_WIDTH    = 13,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          done1,
   input  logic                          done2,
   input  logic                          done3,
   input  logic                          done4,
   input  logic signed [POWER_WIDTH-1:0] power_in_1,
   input  logic signed [POWER_WIDTH-1:0] power_in_2,
   input  logic signed [POWER_WIDTH-1:0] power_in_3,
   input  logic signed [POWER_WIDTH-1:0] power_in_4,
   input  logic                          frame_ready,
   output logic                          frame_valid,
   output logic signed [POWER_WIDTH-1:0] power_1,
   output logic signed [POWER_WIDTH-1:0] power_2,
   output logic signed [POWER_WIDTH-1:0] power_3,
   output logic signed [POWER_WIDTH-1:0] power_4,
   output logic [3:0]                    frame_mask,
   output logic                          frame_partial,
   output logic [CNT_WIDTH-1:0]          overrun_count,
   output logic [CNT_WIDTH-1:0]          drop_count,
   output logic [CNT_WIDTH-1:0]          timeout_count,
   output logic                          busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;

   state_t                        state_reg;
   logic [3:0]                    done_vec;
   logic signed [POWER_WIDTH-1:0] power_in_arr [4];
   logic signed [POWER_WIDTH-1:0] cap_reg [4];
   logic signed [POWER_WIDTH-1:0] cap_next [4];
   logic signed [POWER_WIDTH-1:0] out_reg [4];
   logic [3:0]                    mask_reg, mask_next, out_mask_reg;
   logic                          partial_reg, out_partial_reg, valid_reg;
   logic [TIMER_WIDTH-1:0]        timer_reg, timer_inc;
   logic [CNT_WIDTH-1:0]          overrun_reg, drop_reg, timeout_reg;
   logic                          capture_en, full, timed_out, complete, out_free, transfer;
   logic [2:0]                    overrun_inc, drop_inc;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [2:0] inc);
      logic [CNT_WIDTH:0] sum;
      sum = {1'b0, a} + (CNT_WIDTH+1)'(inc);
      return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
   endfunction

   assign done_vec        = {done4, done3, done2, done1};
   assign power_in_arr[0] = power_in_1;
   assign power_in_arr[1] = power_in_2;
   assign power_in_arr[2] = power_in_3;
   assign power_in_arr[3] = power_in_4;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bin
         assign cap_next[gi] = (capture_en && done_vec[gi]) ? power_in_arr[gi] : cap_reg[gi];
      end
   endgenerate

   // Timeout compares the incremented timer so the frame leaves TIMEOUT_CYCLES after its first strobe.
   always_comb begin
      capture_en  = (state_reg != HOLD);
      mask_next   = capture_en ? (mask_reg | done_vec) : mask_reg;
      timer_inc   = timer_reg + 1'b1;
      full        = (mask_next == 4'hF);
      timed_out   = (state_reg == COLLECT) && !full && (timer_inc == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
      complete    = ((state_reg == IDLE) && full) || ((state_reg == COLLECT) && (full || timed_out));
      out_free    = !valid_reg || frame_ready;
      transfer    = out_free && (complete || (state_reg == HOLD));
      overrun_inc = (state_reg == COLLECT) ? popcount4(done_vec & mask_reg) : 3'd0;
      drop_inc    = (state_reg == HOLD) ? popcount4(done_vec) : 3'd0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= IDLE;
         mask_reg        <= '0;
         partial_reg     <= 1'b0;
         timer_reg       <= '0;
         valid_reg       <= 1'b0;
         out_mask_reg    <= '0;
         out_partial_reg <= 1'b0;
         overrun_reg     <= '0;
         drop_reg        <= '0;
         timeout_reg     <= '0;
         for (int i = 0; i < 4; i++) begin
            cap_reg[i] <= '0;
            out_reg[i] <= '0;
         end
      end else begin
         overrun_reg <= sat_add(overrun_reg, overrun_inc);
         drop_reg    <= sat_add(drop_reg, drop_inc);
         timeout_reg <= sat_add(timeout_reg, {2'b00, timed_out});

         if (transfer) begin
            valid_reg       <= 1'b1;
            out_mask_reg    <= mask_next;
            out_partial_reg <= (state_reg == HOLD) ? partial_reg : timed_out;
            for (int i = 0; i < 4; i++) out_reg[i] <= cap_next[i];
         end else if (valid_reg && frame_ready) begin
            valid_reg <= 1'b0;
         end

         // Cleared collect registers make uncaptured bins read 0 in a partial frame.
         if (transfer) begin
            state_reg   <= IDLE;
            mask_reg    <= '0;
            timer_reg   <= '0;
            partial_reg <= 1'b0;
            for (int i = 0; i < 4; i++) cap_reg[i] <= '0;
         end else if (complete) begin
            state_reg   <= HOLD;
            mask_reg    <= mask_next;
            partial_reg <= timed_out;
            for (int i = 0; i < 4; i++) cap_reg[i] <= cap_next[i];
         end else if (state_reg == IDLE) begin
            if (|done_vec) state_reg <= COLLECT;
            mask_reg  <= mask_next;
            timer_reg <= '0;
            for (int i = 0; i < 4; i++) cap_reg[i] <= cap_next[i];
         end else if (state_reg == COLLECT) begin
            mask_reg  <= mask_next;
            timer_reg <= timer_inc;
            for (int i = 0; i < 4; i++) cap_reg[i] <= cap_next[i];
         end
      end
   end

   assign frame_valid   = valid_reg;
   assign power_1       = out_reg[0];
   assign power_2       = out_reg[1];
   assign power_3       = out_reg[2];
   assign power_4       = out_reg[3];
   assign frame_mask    = out_mask_reg;
   assign frame_partial = out_partial_reg;
   assign overrun_count = overrun_reg;
   assign drop_count    = drop_reg;
   assign timeout_count = timeout_reg;
   assign busy          = (state_reg != IDLE);
endmodule
